// File: rtl/axi_tg_pkg.sv
// Shared types and constants for the AXI write-then-read-check traffic generator.
package axi_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_DONE = 3'd6
  } tg_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_1B    = 3'b000;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/axi_if.sv
// Minimal AXI4 bundle: single-byte data, one strobe bit, no response codes.
interface axi_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic [ID_WIDTH-1:0]   awid;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wstrb;
  logic                  wlast;
  logic                  bvalid;
  logic                  bready;
  logic [ID_WIDTH-1:0]   bid;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [ID_WIDTH-1:0]   arid;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ID_WIDTH-1:0]   rid;
  logic                  rlast;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, awid,
    output wvalid, wdata, wstrb, wlast, bready,
    output arvalid, araddr, arlen, arsize, arburst, arid, rready,
    input  awready, wready, bvalid, bid, arready, rvalid, rdata, rid, rlast
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst, awid,
    input  wvalid, wdata, wstrb, wlast, bready,
    input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
    output awready, wready, bvalid, bid, arready, rvalid, rdata, rid, rlast
  );

endinterface

// File: rtl/axi_tg_pattern.sv
// Data pattern generator: seed plus beat index, wrapping at the data width.
module axi_tg_pattern #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_seed,
  input  logic [7:0]            i_beat,
  output logic [DATA_WIDTH-1:0] o_data
);

  assign o_data = i_seed + DATA_WIDTH'(i_beat);

endmodule

// File: rtl/axi_traffic_gen.sv
// Writes one INCR burst of seed+beat data, reads it back and counts data and
// protocol mismatches; outputs are decoded from the next state and registered.
module axi_traffic_gen
  import axi_tg_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [7:0]            cfg_len,
  input  logic [ID_WIDTH-1:0]   cfg_id,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  axi_if.master                 m_axi,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            err_cnt,
  output logic                  proto_err
);

  tg_state_e             r_state;
  tg_state_e             w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0] r_seed;
  logic [7:0]            r_beat;
  logic [7:0]            r_err_cnt;
  logic                  r_proto_err;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_busy;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] w_pattern;
  logic                  w_last_beat;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_ar_hs;
  logic                  w_r_hs;

  axi_tg_pattern #(.DATA_WIDTH(DATA_WIDTH)) u_pattern (
    .i_seed (r_seed),
    .i_beat (r_beat),
    .o_data (w_pattern)
  );

  assign w_last_beat = (r_beat == r_len);
  assign w_aw_hs     = r_awvalid & m_axi.awready;
  assign w_w_hs      = r_wvalid  & m_axi.wready;
  assign w_b_hs      = r_bready  & m_axi.bvalid;
  assign w_ar_hs     = r_arvalid & m_axi.arready;
  assign w_r_hs      = r_rready  & m_axi.rvalid;

  // State register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; DONE never looks at start so a coincident start is dropped
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)        w_state_nxt = ST_AW;   else w_state_nxt = ST_IDLE;
      ST_AW:   if (w_aw_hs)      w_state_nxt = ST_W;    else w_state_nxt = ST_AW;
      ST_W:    if (w_w_hs && w_last_beat) w_state_nxt = ST_B; else w_state_nxt = ST_W;
      ST_B:    if (w_b_hs)       w_state_nxt = ST_AR;   else w_state_nxt = ST_B;
      ST_AR:   if (w_ar_hs)      w_state_nxt = ST_R;    else w_state_nxt = ST_AR;
      ST_R:    if (w_r_hs && w_last_beat) w_state_nxt = ST_DONE; else w_state_nxt = ST_R;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake strobes registered from the next state so they match r_state exactly
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_awvalid <= (w_state_nxt == ST_AW);
      r_wvalid  <= (w_state_nxt == ST_W);
      r_bready  <= (w_state_nxt == ST_B);
      r_arvalid <= (w_state_nxt == ST_AR);
      r_rready  <= (w_state_nxt == ST_R);
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= (w_state_nxt == ST_DONE);
    end
  end

  // Configuration latch, beat counter and result accumulation
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_addr      <= '0;
      r_len       <= 8'd0;
      r_id        <= '0;
      r_seed      <= '0;
      r_beat      <= 8'd0;
      r_err_cnt   <= 8'd0;
      r_proto_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr      <= cfg_addr;
            r_len       <= cfg_len;
            r_id        <= cfg_id;
            r_seed      <= cfg_seed;
            r_beat      <= 8'd0;
            r_err_cnt   <= 8'd0;
            r_proto_err <= 1'b0;
          end
        end
        ST_W: begin
          if (w_w_hs) begin
            r_beat <= w_last_beat ? 8'd0 : r_beat + 8'd1;
          end
        end
        ST_B: begin
          if (w_b_hs && (m_axi.bid != r_id)) begin
            r_proto_err <= 1'b1;
          end
        end
        ST_R: begin
          if (w_r_hs) begin
            if (m_axi.rdata != w_pattern) begin
              r_err_cnt <= sat_inc8(r_err_cnt);
            end
            // RLAST must coincide with the final beat, no earlier and no later
            if ((m_axi.rid != r_id) || (m_axi.rlast != w_last_beat)) begin
              r_proto_err <= 1'b1;
            end
            r_beat <= w_last_beat ? 8'd0 : r_beat + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign m_axi.awvalid = r_awvalid;
  assign m_axi.awaddr  = r_addr;
  assign m_axi.awlen   = r_len;
  assign m_axi.awsize  = AXI_SIZE_1B;
  assign m_axi.awburst = AXI_BURST_INCR;
  assign m_axi.awid    = r_id;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.wdata   = w_pattern;
  assign m_axi.wstrb   = 1'b1;
  assign m_axi.wlast   = r_wvalid & w_last_beat;
  assign m_axi.bready  = r_bready;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.araddr  = r_addr;
  assign m_axi.arlen   = r_len;
  assign m_axi.arsize  = AXI_SIZE_1B;
  assign m_axi.arburst = AXI_BURST_INCR;
  assign m_axi.arid    = r_id;
  assign m_axi.rready  = r_rready;

  assign busy      = r_busy;
  assign done      = r_done;
  assign err_cnt   = r_err_cnt;
  assign proto_err = r_proto_err;

endmodule
